// File: rtl/bch_packet_serializer.sv
// HDMI data-island packet serializer: one-entry input buffer, per-block BCH parity,
// one pixel of header/subpacket lane bits per clock toward the TERC4 encoders.
module bch_packet_serializer #(
    parameter int                      SUBPACKETS  = 4,
    parameter int                      HEADER_BITS = 24,
    parameter int                      SUB_BITS    = 56,
    parameter int                      PARITY_BITS = 8,
    parameter logic [PARITY_BITS-1:0]  POLY        = 8'b10000011
) (
    input  logic                      clk_pixel,
    input  logic                      reset,
    input  logic                      data_island_period,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [HEADER_BITS-1:0]    header,
    input  logic [SUB_BITS-1:0]       sub [SUBPACKETS],
    output logic [2*SUBPACKETS:0]     packet_data,
    output logic                      packet_enable,
    output logic                      null_sent,
    output logic                      packet_aborted
);

    localparam int LEN = HEADER_BITS + PARITY_BITS;
    localparam int CW  = $clog2(LEN);
    localparam int BW  = 2 * LEN;

    typedef logic [PARITY_BITS-1:0] par_t;

    if (SUB_BITS + PARITY_BITS != 2 * LEN) begin : g_bad_geometry
        $error("SUB_BITS + PARITY_BITS must equal 2*(HEADER_BITS + PARITY_BITS)");
    end

    function automatic par_t ecc_step(input par_t e, input logic b);
        return (e[0] ^ b) ? ((e >> 1) ^ POLY) : (e >> 1);
    endfunction

    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    pend_full_q, pend_full_d;
    logic [HEADER_BITS-1:0]  pend_hdr_q, pend_hdr_d;
    logic [SUB_BITS-1:0]     pend_sub_q [SUBPACKETS];
    logic [SUB_BITS-1:0]     pend_sub_d [SUBPACKETS];
    logic [HEADER_BITS-1:0]  act_hdr_q, act_hdr_d;
    logic [SUB_BITS-1:0]     act_sub_q [SUBPACKETS];
    logic [SUB_BITS-1:0]     act_sub_d [SUBPACKETS];
    par_t                    par_hdr_q, par_hdr_d;
    par_t                    par_sub_q [SUBPACKETS];
    par_t                    par_sub_d [SUBPACKETS];
    logic [2*SUBPACKETS:0]   pd_q, pd_d;
    logic                    en_q, en_d;
    logic                    null_q, null_d;
    logic                    abort_q, abort_d;

    logic [31:0]             pix_w;
    logic                    at_start, at_end;
    logic [HEADER_BITS-1:0]  src_hdr;
    logic [SUB_BITS-1:0]     src_sub [SUBPACKETS];
    logic [LEN-1:0]          hdr_blk;
    logic [BW-1:0]           sub_blk [SUBPACKETS];
    logic [2*SUBPACKETS:0]   pixel;
    par_t                    step1;

    // Pixel datapath: slot 0 reads straight from the capture mux, later pixels from the active copy.
    always_comb begin
        pix_w    = 32'(cnt_q);
        at_start = (cnt_q == '0);
        at_end   = (pix_w == 32'(LEN - 1));
        src_hdr  = at_start ? (pend_full_q ? pend_hdr_q : '0) : act_hdr_q;
        hdr_blk  = {par_hdr_q, src_hdr};
        pixel    = '0;
        pixel[0] = hdr_blk[cnt_q];
        for (int j = 0; j < SUBPACKETS; j++) begin
            src_sub[j] = at_start ? (pend_full_q ? pend_sub_q[j] : '0) : act_sub_q[j];
            sub_blk[j] = {par_sub_q[j], src_sub[j]};
            pixel[1 + j]              = sub_blk[j][{cnt_q, 1'b0}];
            pixel[1 + SUBPACKETS + j] = sub_blk[j][{cnt_q, 1'b1}];
        end
    end

    always_comb begin
        cnt_d       = cnt_q;
        pend_full_d = pend_full_q;
        pend_hdr_d  = pend_hdr_q;
        pend_sub_d  = pend_sub_q;
        act_hdr_d   = act_hdr_q;
        act_sub_d   = act_sub_q;
        par_hdr_d   = par_hdr_q;
        par_sub_d   = par_sub_q;
        pd_d        = '0;
        en_d        = 1'b0;
        null_d      = 1'b0;
        abort_d     = 1'b0;
        step1       = '0;

        // A load can never coincide with a capture: loads need the buffer empty, captures need it full.
        if (in_valid && !pend_full_q) begin
            pend_full_d = 1'b1;
            pend_hdr_d  = header;
            pend_sub_d  = sub;
        end

        if (data_island_period) begin
            pd_d   = pixel;
            en_d   = at_start;
            null_d = at_start && !pend_full_q;
            cnt_d  = at_end ? '0 : cnt_q + 1'b1;
            if (at_start) begin
                act_hdr_d = src_hdr;
                act_sub_d = src_sub;
                if (pend_full_q) pend_full_d = 1'b0;
            end
            if (at_end) begin
                par_hdr_d = '0;
                for (int j = 0; j < SUBPACKETS; j++) par_sub_d[j] = '0;
            end else begin
                if (pix_w < 32'(HEADER_BITS)) par_hdr_d = ecc_step(par_hdr_q, hdr_blk[cnt_q]);
                if ((pix_w << 1) < 32'(SUB_BITS)) begin
                    for (int j = 0; j < SUBPACKETS; j++) begin
                        step1        = ecc_step(par_sub_q[j], sub_blk[j][{cnt_q, 1'b0}]);
                        par_sub_d[j] = ecc_step(step1, sub_blk[j][{cnt_q, 1'b1}]);
                    end
                end
            end
        end else if (!at_start) begin
            cnt_d     = '0;
            par_hdr_d = '0;
            for (int j = 0; j < SUBPACKETS; j++) par_sub_d[j] = '0;
            abort_d   = 1'b1;
        end
    end

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            cnt_q       <= '0;
            pend_full_q <= 1'b0;
            par_hdr_q   <= '0;
            for (int j = 0; j < SUBPACKETS; j++) par_sub_q[j] <= '0;
            pd_q        <= '0;
            en_q        <= 1'b0;
            null_q      <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            pend_full_q <= pend_full_d;
            par_hdr_q   <= par_hdr_d;
            par_sub_q   <= par_sub_d;
            pd_q        <= pd_d;
            en_q        <= en_d;
            null_q      <= null_d;
            abort_q     <= abort_d;
        end
    end

    // Packet payload storage is qualified by pend_full_q / cnt_q, so it needs no reset.
    always_ff @(posedge clk_pixel) begin
        pend_hdr_q <= pend_hdr_d;
        pend_sub_q <= pend_sub_d;
        act_hdr_q  <= act_hdr_d;
        act_sub_q  <= act_sub_d;
    end

    assign in_ready       = !pend_full_q;
    assign packet_data    = pd_q;
    assign packet_enable  = en_q;
    assign null_sent      = null_q;
    assign packet_aborted = abort_q;

endmodule

// File: tb/tb_bch_packet_serializer.sv
// Directed bench for bch_packet_serializer: hand-computed vector table plus
// bit-serial ECC reference for random packets and multi-cycle corner cases.
module tb_bch_packet_serializer;

    localparam int LEN = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, dip, vld, rdy;
    logic [23:0] hdr;
    logic [55:0] sub [4];
    logic [8:0]  pd;
    logic        en, nul, abt;

    logic        dip2, vld2, rdy2;
    logic [23:0] hdr2;
    logic [55:0] sub2 [2];
    logic [4:0]  pd2;
    logic        en2, nul2, abt2;

    bch_packet_serializer u1 (
        .clk_pixel(clk), .reset(rst), .data_island_period(dip),
        .in_valid(vld), .in_ready(rdy), .header(hdr), .sub(sub),
        .packet_data(pd), .packet_enable(en), .null_sent(nul), .packet_aborted(abt)
    );

    bch_packet_serializer #(.SUBPACKETS(2)) u2 (
        .clk_pixel(clk), .reset(rst), .data_island_period(dip2),
        .in_valid(vld2), .in_ready(rdy2), .header(hdr2), .sub(sub2),
        .packet_data(pd2), .packet_enable(en2), .null_sent(nul2), .packet_aborted(abt2)
    );

    int tests = 0;
    int fails = 0;

    typedef struct {
        int         pix;
        logic [8:0] word;
    } vec_t;

    vec_t        tbl [7];
    logic [8:0]  w_hand [32];
    logic [8:0]  wa [32], wb [32], wc [32], wd [32], wg [32];
    logic [55:0] sa [4], sb [4], sc [4], sd [4], se [4], sf [4], sg [4], zs [4];
    logic [23:0] ha, hb, hc, hd, hg;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic chk_pix(input string tag, input int k, input logic [8:0] w,
                           input logic e, input logic n);
        chk($sformatf("%s_pix%0d", tag, k), 32'({nul, en, pd}), 32'({n, e, w}));
    endtask

    function automatic logic [7:0] step(input logic [7:0] e, input logic b);
        return (e[0] ^ b) ? ((e >> 1) ^ 8'h83) : (e >> 1);
    endfunction

    // Reference: compute each block's parity over its whole data field, then slice into pixels.
    task automatic model(input logic [23:0] h, input logic [55:0] s [4], input int ns,
                         output logic [8:0] w [32]);
        logic [7:0]  p;
        logic [31:0] hbk;
        logic [63:0] sbk [4];
        p = '0;
        for (int i = 0; i < 24; i++) p = step(p, h[i]);
        hbk = {p, h};
        for (int j = 0; j < 4; j++) begin
            p = '0;
            for (int i = 0; i < 56; i++) p = step(p, s[j][i]);
            sbk[j] = {p, s[j]};
        end
        for (int k = 0; k < 32; k++) begin
            w[k]    = '0;
            w[k][0] = hbk[k];
            for (int j = 0; j < ns; j++) begin
                w[k][1 + j]      = sbk[j][2 * k];
                w[k][1 + ns + j] = sbk[j][2 * k + 1];
            end
        end
    endtask

    task automatic rand_sub(output logic [55:0] s [4]);
        logic [63:0] t;
        for (int j = 0; j < 4; j++) begin
            t    = {$urandom(), $urandom()};
            s[j] = t[55:0];
        end
    endtask

    task automatic offer(input logic [23:0] h, input logic [55:0] s [4]);
        hdr = h;
        sub = s;
        vld = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        // Header 24'h000084 parity is 8'hD4; sub[1]={bit55} gives parity 8'h83.
        tbl = '{'{2, 9'h001}, '{7, 9'h001}, '{26, 9'h001}, '{27, 9'h040},
                '{28, 9'h045}, '{30, 9'h001}, '{31, 9'h041}};
        for (int k = 0; k < 32; k++) w_hand[k] = '0;
        foreach (tbl[i]) w_hand[tbl[i].pix] = tbl[i].word;

        for (int j = 0; j < 4; j++) zs[j] = '0;
        ha = 24'h000084; rand_sub(sa); model(ha, sa, 4, wa);
        hb = 24'($urandom()); rand_sub(sb); model(hb, sb, 4, wb);
        hc = 24'($urandom()); rand_sub(sc);
        hd = 24'($urandom()); rand_sub(sd); model(hd, sd, 4, wd);
        rand_sub(se); rand_sub(sf);
        hg = 24'($urandom()); rand_sub(sg); sg[2] = '0; sg[3] = '0; model(hg, sg, 2, wg);
        model(hc, sc, 4, wc);

        rst = 1'b1; dip = 1'b0; vld = 1'b0; hdr = '0; sub = zs;
        dip2 = 1'b0; vld2 = 1'b0; hdr2 = '0; sub2[0] = '0; sub2[1] = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst_pd", 32'(pd), 32'h0);
        chk("rst_en", 32'(en), 32'h0);
        chk("rst_null", 32'(nul), 32'h0);
        chk("rst_abort", 32'(abt), 32'h0);
        chk("rst_ready", 32'(rdy), 32'h1);

        // Null packet slot
        dip = 1'b1;
        for (int k = 0; k < LEN; k++) begin
            tick();
            chk_pix("null", k, 9'h0, k == 0, k == 0);
        end
        dip = 1'b0;
        tick();
        chk("null_idle", 32'({en, pd}), 32'h0);

        // Hand-computed packet from the vector table
        sub = zs;
        sub[1] = 56'h80000000000000;
        hdr = 24'h000084;
        vld = 1'b1;
        tick();
        vld = 1'b0;
        chk("hand_ready_low", 32'(rdy), 32'h0);
        dip = 1'b1;
        for (int k = 0; k < LEN; k++) begin
            tick();
            chk_pix("hand", k, w_hand[k], k == 0, 1'b0);
            if (k == 0) chk("hand_ready_after_cap", 32'(rdy), 32'h1);
        end
        dip = 1'b0;
        tick();

        // Back-to-back: A then B, B offered during A
        offer(ha, sa);
        tick();
        vld = 1'b0;
        dip = 1'b1;
        for (int k = 0; k < 2 * LEN; k++) begin
            tick();
            chk_pix("b2b", k, (k < LEN) ? wa[k] : wb[k - LEN], (k % LEN) == 0, 1'b0);
            if (k == 3) offer(hb, sb);
            if (k == 4) begin
                vld = 1'b0;
                chk("b2b_ready_low", 32'(rdy), 32'h0);
            end
            if (k == LEN - 1) chk("b2b_ready_before_cap", 32'(rdy), 32'h0);
            if (k == LEN) chk("b2b_ready_after_cap", 32'(rdy), 32'h1);
        end
        dip = 1'b0;
        tick();
        chk("b2b_idle", 32'(pd), 32'h0);

        // Abort at cnt==10 with D pending
        offer(hc, sc);
        tick();
        vld = 1'b0;
        dip = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk_pix("abortC", k, wc[k], k == 0, 1'b0);
            if (k == 1) offer(hd, sd);
            if (k == 2) vld = 1'b0;
        end
        dip = 1'b0;
        tick();
        chk("abort_pulse", 32'(abt), 32'h1);
        chk("abort_pd_zero", 32'(pd), 32'h0);
        tick();
        chk("abort_pulse_end", 32'(abt), 32'h0);
        dip = 1'b1;
        for (int k = 0; k < LEN; k++) begin
            tick();
            chk_pix("abortD", k, wd[k], k == 0, 1'b0);
            if (k == 0) chk("abort_ready_after_cap", 32'(rdy), 32'h1);
        end
        dip = 1'b0;
        tick();

        // Asynchronous reset at cnt==17 with a pending packet
        offer(24'hFFFFFF, se);
        tick();
        vld = 1'b0;
        dip = 1'b1;
        for (int k = 0; k < 17; k++) begin
            tick();
            chk("rstE_hdrbit", 32'(pd[0]), 32'h1);
            if (k == 2) offer(24'h123456, sf);
            if (k == 3) vld = 1'b0;
        end
        #1;
        rst = 1'b1;
        dip = 1'b0;
        #1;
        chk("rst_async_outputs", 32'({abt, nul, en, pd}), 32'h0);
        tick();
        rst = 1'b0;
        tick();
        chk("rst_ready_after_release", 32'(rdy), 32'h1);
        dip = 1'b1;
        for (int k = 0; k < LEN; k++) begin
            tick();
            chk_pix("rst_null", k, 9'h0, k == 0, k == 0);
        end
        dip = 1'b0;
        tick();

        // Two-subpacket instance
        hdr2 = hg; sub2[0] = sg[0]; sub2[1] = sg[1]; vld2 = 1'b1;
        tick();
        vld2 = 1'b0;
        dip2 = 1'b1;
        for (int k = 0; k < LEN; k++) begin
            tick();
            chk($sformatf("s2_pix%0d", k), 32'({nul2, en2, pd2}), 32'({1'b0, k == 0, wg[k][4:0]}));
        end
        dip2 = 1'b0;
        tick();
        chk("s2_idle", 32'(pd2), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
